bpsk_demodulator: RTL
=====================

# bpsk_demodulator

Coherent BPSK receiver, the decode partner of the BPSK modulator. It multiplies a sampled BPSK waveform by a locally generated reference carrier from the waveform_gen DDS. It integrates the products over one symbol period (integrate-and-dump), then slices the sign of the correlation to recover the transmitted bit. It sits after the modulator/channel path and feeds recovered bits to the bit checker or the Nios-visible status logic.

## Interface
- `DATA_W`, 12: width of signed sample and reference inputs.
- `SAMPLES_PER_SYMBOL`, 16: qualified samples integrated per symbol; must be ≥ 1.
- `ACC_W`, 32: accumulator width; must be ≥ 2*DATA_W + clog2(SAMPLES_PER_SYMBOL).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_en`  in  1  qualifies `bpsk_in`/`carrier_ref` this cycle.
- `bpsk_in`  in  DATA_W  signed (2's complement) received BPSK sample.
- `carrier_ref`  in  DATA_W  signed coherent reference (DDS sin_out).
- `sym_start`  in  1  symbol-alignment pulse; the current or next qualified sample becomes sample 0.
- `bit_out`  out  1  recovered bit, held until the next decision.
- `bit_valid`  out  1  one-cycle pulse when `bit_out`/`corr_out` update.
- `corr_out`  out  ACC_W  signed final correlation of the last symbol.
- `sym_count`  out  clog2(SAMPLES_PER_SYMBOL+1)  samples taken so far in the current symbol.

## Operation
- Reset values: `bit_out`=0, `bit_valid`=0, `corr_out`=0, `sym_count`=0. The accumulator and all pipeline valid flags are cleared.
- Stage 1 is registered on a `sample_en` cycle:
  - prod = bpsk_in * carrier_ref, full 2*DATA_W signed.
  - Flag first = (count==0), flag last = (count==SAMPLES_PER_SYMBOL-1).
  - count increments, or wraps to 0 after last.
- Stage 2 runs when the stage-1 valid flag is set:
  - acc = first ? sext(prod) : acc + sext(prod).
  - If last: corr_out ← new acc, decision d = (new acc > 0), bit_out ← d, bit_valid=1 next cycle.
  - Zero correlation decides 0.
- Bit mapping: carrier in phase with reference → 1; inverted → 0.
- `sym_start` handling:
  - Without `sample_en`: count←0.
  - With `sample_en`: the sample is tagged first and count←1.
  - A product already in stage 1 completes into the old symbol, and may dump if it was last.
  - A partial old symbol is otherwise dropped with no `bit_valid`.
- SAMPLES_PER_SYMBOL=1: every sample is both first and last; one decision per sample.
- Arithmetic is wrap-around two's complement. No saturation, because the parameter constraint prevents overflow.
- Reset mid-symbol: everything clears at once and the partial symbol is discarded. The next sample is sample 0.

## Timing
- Sample accepted on edge E0; accumulate/dump on edge E1.
- `bit_valid` is high for exactly the one cycle after E1, with `bit_out`/`corr_out` valid in the same cycle. Latency is 2 clocks from the final sample's edge.
- Back-to-back `sample_en` is supported at full clock rate. Gaps in `sample_en` stall without loss.
- `sym_count` updates on E0, one cycle after the sample is presented.

## Configuration
- `BPSK_DEMOD_DIFF_EN` defined: differential decoding, bit_out = d[n] XOR d[n-1].
  - d[n-1] resets to 0 on `reset` only; `sym_start` does not clear it.
  - `corr_out` is unaffected.
- Undefined: bit_out = d[n] (absolute coherent decision). The previous-decision register is not built.

## Test plan
All scenarios use SAMPLES_PER_SYMBOL=4 and DATA_W=12.
- In-phase: bpsk_in=100, carrier_ref=100, 4 consecutive `sample_en` cycles → `bit_valid` 2 clocks after the 4th sample, corr_out=40000, bit_out=1.
- Inverted: bpsk_in=-100, carrier_ref=100 → corr_out=-40000, bit_out=0. Extremes bpsk_in=-2048, carrier_ref=-2048 → corr_out=16777216, no overflow.
- Zero input for a full symbol → corr_out=0, bit_out=0, one `bit_valid` pulse.
- Gapped `sample_en` (every 3rd cycle), alternating in-phase/inverted symbols → bits 1,0,1,0 with exactly one `bit_valid` per 4 samples.
- `sym_start` with the 3rd sample of a symbol → no decision for the partial symbol; the next decision comes after 3 more samples and integrates only the 4 new ones.
- Reset asserted after 2 samples → all outputs 0 immediately; the next 4 samples give one correct decision. With `BPSK_DEMOD_DIFF_EN`, symbols 1,1,0,0 give bit_out 1,0,1,0.

Source files
------------

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK integrate-and-dump demodulator: multiply by reference, sum per symbol, slice sign.
// Optional differential decoding when BPSK_DEMOD_DIFF_EN is defined.
module bpsk_demodulator #(
    parameter int DATA_W             = 12,
    parameter int SAMPLES_PER_SYMBOL = 16,
    parameter int ACC_W              = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        sample_en,
    input  logic signed [DATA_W-1:0]                    bpsk_in,
    input  logic signed [DATA_W-1:0]                    carrier_ref,
    input  logic                                        sym_start,
    output logic                                        bit_out,
    output logic                                        bit_valid,
    output logic signed [ACC_W-1:0]                     corr_out,
    output logic [$clog2(SAMPLES_PER_SYMBOL+1)-1:0]     sym_count
);

    localparam int CNT_W  = $clog2(SAMPLES_PER_SYMBOL + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic SINGLE = (SAMPLES_PER_SYMBOL == 1);

    logic [CNT_W-1:0]          count_q, count_d;
    logic                      s1_valid_q;
    logic                      first_q, first_d;
    logic                      last_q, last_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   corr_q;
    logic                      bit_q, bit_d;
    logic                      valid_q;
    logic                      dec;

    // Stage 1: product and symbol position tagging; sym_start forces a new sample 0.
    always_comb begin
        first_d = sym_start || (count_q == '0);
        last_d  = sym_start ? SINGLE : (count_q == LAST_CNT);
        prod_d  = PROD_W'(bpsk_in) * PROD_W'(carrier_ref);
        count_d = count_q;
        if (sample_en) begin
            if (last_d)
                count_d = '0;
            else if (sym_start)
                count_d = CNT_W'(1);
            else
                count_d = count_q + CNT_W'(1);
        end else if (sym_start) begin
            count_d = '0;
        end
    end

    // Stage 2: integrate-and-dump with sign slicing; zero correlation decides 0.
    always_comb begin
        prod_ext = ACC_W'(prod_q);
        acc_d    = first_q ? prod_ext : acc_q + prod_ext;
        dec      = !acc_d[ACC_W-1] && (acc_d != '0);
    end

`ifdef BPSK_DEMOD_DIFF_EN
    logic prev_q;

    always_comb begin
        bit_d = dec ^ prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_q <= 1'b0;
        else if (s1_valid_q && last_q)
            prev_q <= dec;
    end
`else
    always_comb begin
        bit_d = dec;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            corr_q     <= '0;
            bit_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            s1_valid_q <= sample_en;
            if (sample_en) begin
                prod_q  <= prod_d;
                first_q <= first_d;
                last_q  <= last_d;
            end
            valid_q <= s1_valid_q && last_q;
            if (s1_valid_q) begin
                acc_q <= acc_d;
                if (last_q) begin
                    corr_q <= acc_d;
                    bit_q  <= bit_d;
                end
            end
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign corr_out  = corr_q;
    assign sym_count = count_q;

endmodule
